// File: rtl/cpu_pkg.sv
// Shared CPU-front-end types: clock-mode state encoding used by the step controller.
package cpu_pkg;

   typedef enum logic [1:0] {
      CM_MANUAL = 2'd0,
      CM_AUTO   = 2'd1,
      CM_HALTED = 2'd2
   } clk_mode_t;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter for one raw board input.
module input_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic raw_i,
   output logic db_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         db_o  <= 1'b0;
      end else begin
         sync1 <= raw_i;
         sync2 <= sync1;
         // Any cycle where the synced value agrees with db_o restarts the run.
         if (sync2 != db_o) begin
            if (cnt == CNT_LAST) begin
               db_o <= sync2;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/clock_step_ctrl.sv
// CPU clock-enable front end: AUTO divider tick or MANUAL debounced step pulse, frozen by halt.
//
//  state     | meaning
//  CM_MANUAL | one enable pulse per debounced step press
//  CM_AUTO   | free-running enable every AUTO_DIV cycles
//  CM_HALTED | CPU halted; outputs frozen until reset
module clock_step_ctrl
   import cpu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int AUTO_DIV        = 8
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic mode_i,
   input  logic step_i,
   input  logic halt_i,
   output logic cpu_clk_en_o,
   output logic mode_o,
   output logic halted_o
);

   localparam int DIV_W = $clog2(AUTO_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

   clk_mode_t        state;
   logic [DIV_W-1:0] div;
   logic             db_mode;
   logic             db_step;
   logic             db_step_q;
   logic             step_rise;

   input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk    (clk),
      .rst_ni (rst_ni),
      .raw_i  (mode_i),
      .db_o   (db_mode)
   );

   input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .clk    (clk),
      .rst_ni (rst_ni),
      .raw_i  (step_i),
      .db_o   (db_step)
   );

   assign step_rise = db_step & ~db_step_q;

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         state        <= CM_MANUAL;
         div          <= '0;
         db_step_q    <= 1'b0;
         cpu_clk_en_o <= 1'b0;
         mode_o       <= 1'b0;
         halted_o     <= 1'b0;
      end else begin
         db_step_q    <= db_step;
         cpu_clk_en_o <= 1'b0;
         case (state)
            CM_MANUAL: begin
               if (halt_i) begin
                  state    <= CM_HALTED;
                  halted_o <= 1'b1;
               end else if (db_mode) begin
                  // A step edge coinciding with the switch to AUTO is dropped.
                  state  <= CM_AUTO;
                  div    <= '0;
                  mode_o <= 1'b1;
               end else begin
                  cpu_clk_en_o <= step_rise;
               end
            end
            CM_AUTO: begin
               if (halt_i) begin
                  state    <= CM_HALTED;
                  mode_o   <= 1'b0;
                  halted_o <= 1'b1;
               end else if (!db_mode) begin
                  state  <= CM_MANUAL;
                  div    <= '0;
                  mode_o <= 1'b0;
               end else begin
                  cpu_clk_en_o <= (div == DIV_LAST);
                  div          <= (div == DIV_LAST) ? '0 : div + 1'b1;
               end
            end
            default: begin
               state    <= CM_HALTED;
               mode_o   <= 1'b0;
               halted_o <= 1'b1;
            end
         endcase
      end
   end

endmodule
